// File: rtl/cu_pkg.sv
// cu_pkg: shared types and constants for the multi-cycle RV32I control unit.
//   - state_t  : control FSM states
//   - cls_t    : instruction class latched in DECODE
//   - OP_*     : RV32I major opcodes (IR[6:0])
//   - SRCA_*, SRCB_*, ALUOP_*, PCSRC_*, WB_* : datapath select encodings
//   - CAUSE_*  : trap cause encodings
package cu_pkg;

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  typedef enum logic [3:0] {
    CL_R       = 4'd0,
    CL_IALU    = 4'd1,
    CL_LOAD    = 4'd2,
    CL_STORE   = 4'd3,
    CL_BRANCH  = 4'd4,
    CL_JAL     = 4'd5,
    CL_JALR    = 4'd6,
    CL_LUI     = 4'd7,
    CL_AUIPC   = 4'd8,
    CL_ILLEGAL = 4'd9
  } cls_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] SRCA_PC     = 2'b00;
  localparam logic [1:0] SRCA_PC_OLD = 2'b01;
  localparam logic [1:0] SRCA_RS1    = 2'b10;
  localparam logic [1:0] SRCA_ZERO   = 2'b11;

  localparam logic [1:0] SRCB_RS2    = 2'b00;
  localparam logic [1:0] SRCB_IMM    = 2'b01;
  localparam logic [1:0] SRCB_CONST4 = 2'b10;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RFUNCT = 2'b10;
  localparam logic [1:0] ALUOP_IFUNCT = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;

  localparam logic [1:0] WB_ALUOUT = 2'b00;
  localparam logic [1:0] WB_MDR    = 2'b01;
  localparam logic [1:0] WB_PC4    = 2'b10;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

endpackage

// File: rtl/cu_opcode_classifier.sv
// cu_opcode_classifier: purely combinational mapping from the RV32I major
// opcode to an instruction class. Kept separate so a pipelined decoder can
// reuse it.
//   opcode [6:0] in  : IR[6:0]
//   cls          out : instruction class, CL_ILLEGAL for unknown opcodes
module cu_opcode_classifier
  import cu_pkg::*;
(
  input  logic [6:0] opcode,
  output cls_t       cls
);

  always_comb begin
    cls = CL_ILLEGAL;
    case (opcode)
      OP_R:      cls = CL_R;
      OP_IALU:   cls = CL_IALU;
      OP_LOAD:   cls = CL_LOAD;
      OP_STORE:  cls = CL_STORE;
      OP_BRANCH: cls = CL_BRANCH;
      OP_JAL:    cls = CL_JAL;
      OP_JALR:   cls = CL_JALR;
      OP_LUI:    cls = CL_LUI;
      OP_AUIPC:  cls = CL_AUIPC;
      default:   cls = CL_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/mc_control_unit.sv
// mc_control_unit: multi-cycle RV32I control FSM sequencing
// RESET -> FETCH -> DECODE -> EXEC -> [MEM] -> [WB] -> FETCH over a shared
// datapath with a single req/ack memory port.
//
// Optional feature macro: CU_TRAP_EN
//   defined   : illegal opcodes and memory timeouts enter TRAP (left only by rst)
//   undefined : illegal opcodes act as NOPs, memory waits are unbounded,
//               fault/trap_cause tied to 0
//
// Parameters:
//   MEM_TIMEOUT : cycles mem_req may wait for mem_ack before a timeout (0 = off)
//   TO_W        : timeout counter width, 2**TO_W > MEM_TIMEOUT
//
// Ports:
//   clk, rst (sync, active high)
//   opcode[6:0]      : IR[6:0], sampled in DECODE only
//   mem_ack          : memory transfer complete this cycle
//   mem_req, mem_we, iord                 : memory interface controls
//   ir_write, pc_write, pc_src[1:0]       : IR / PC load controls
//   alu_src_a, alu_src_b, alu_op [1:0]    : ALU operand / operation selects
//   branch, reg_write, wb_sel[1:0]        : branch qualify, register write-back
//   fault, trap_cause[1:0]                : trap status
module mc_control_unit
  import cu_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int TO_W        = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic       mem_ack,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       branch,
  output logic       reg_write,
  output logic [1:0] wb_sel,
  output logic       fault,
  output logic [1:0] trap_cause
);

  state_t state;
  cls_t   cls;
  cls_t   dec_cls;

  cu_opcode_classifier u_classifier (
    .opcode (opcode),
    .cls    (dec_cls)
  );

`ifdef CU_TRAP_EN
  logic [TO_W-1:0] to_cnt;
  logic [1:0]      cause;
  logic            timeout;

  // A coincident ack always wins over the timeout.
  assign timeout = (MEM_TIMEOUT != 0) && mem_req && !mem_ack &&
                   (to_cnt == TO_W'(MEM_TIMEOUT - 1));
`endif

  // State, latched class and trap bookkeeping. The class is captured once in
  // DECODE so that later states do not depend on the live opcode.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_RESET;
      cls   <= CL_ILLEGAL;
`ifdef CU_TRAP_EN
      to_cnt <= '0;
      cause  <= CAUSE_NONE;
`endif
    end else begin
      case (state)
        S_RESET: state <= S_FETCH;
        S_FETCH: begin
          if (mem_ack) state <= S_DECODE;
`ifdef CU_TRAP_EN
          else if (timeout) begin
            state <= S_TRAP;
            cause <= CAUSE_TIMEOUT;
          end
`endif
        end
        S_DECODE: begin
          cls <= dec_cls;
          if (dec_cls == CL_ILLEGAL) begin
`ifdef CU_TRAP_EN
            state <= S_TRAP;
            cause <= CAUSE_ILLEGAL;
`else
            state <= S_FETCH;
`endif
          end else begin
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          case (cls)
            CL_R, CL_IALU, CL_LUI, CL_AUIPC: state <= S_WB;
            CL_LOAD, CL_STORE:               state <= S_MEM;
            default:                         state <= S_FETCH;
          endcase
        end
        S_MEM: begin
          if (mem_ack) state <= (cls == CL_LOAD) ? S_WB : S_FETCH;
`ifdef CU_TRAP_EN
          else if (timeout) begin
            state <= S_TRAP;
            cause <= CAUSE_TIMEOUT;
          end
`endif
        end
        S_WB: state <= S_FETCH;
`ifdef CU_TRAP_EN
        S_TRAP: state <= S_TRAP;
`endif
        default: state <= S_RESET;
      endcase

`ifdef CU_TRAP_EN
      // mem_req is high exactly in FETCH/MEM, so clearing whenever it is low
      // also covers every entry into those states.
      if (!mem_req || mem_ack) to_cnt <= '0;
      else                     to_cnt <= to_cnt + 1'b1;
`endif
    end
  end

  // Control outputs decoded from registered state and latched class; only
  // ir_write/pc_write in FETCH additionally follow mem_ack.
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PCSRC_ALU;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    alu_op     = ALUOP_ADD;
    branch     = 1'b0;
    reg_write  = 1'b0;
    wb_sel     = WB_ALUOUT;
    fault      = 1'b0;
    trap_cause = CAUSE_NONE;
    case (state)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_a = SRCA_PC;
        alu_src_b = SRCB_CONST4;
        ir_write  = mem_ack;
        pc_write  = mem_ack;
      end
      S_DECODE: begin
        // Precompute branch/JAL target into ALUOut.
        alu_src_a = SRCA_PC_OLD;
        alu_src_b = SRCB_IMM;
      end
      S_EXEC: begin
        case (cls)
          CL_R: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_RS2;
            alu_op    = ALUOP_RFUNCT;
          end
          CL_IALU: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_IMM;
            alu_op    = ALUOP_IFUNCT;
          end
          CL_LOAD, CL_STORE: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_IMM;
          end
          CL_BRANCH: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_RS2;
            alu_op    = ALUOP_BRANCH;
            branch    = 1'b1;
            pc_src    = PCSRC_ALUOUT;
          end
          CL_JAL: begin
            pc_write  = 1'b1;
            pc_src    = PCSRC_ALUOUT;
            reg_write = 1'b1;
            wb_sel    = WB_PC4;
          end
          CL_JALR: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_IMM;
            pc_write  = 1'b1;
            pc_src    = PCSRC_ALU;
            reg_write = 1'b1;
            wb_sel    = WB_PC4;
          end
          CL_LUI: begin
            alu_src_a = SRCA_ZERO;
            alu_src_b = SRCB_IMM;
          end
          CL_AUIPC: begin
            alu_src_a = SRCA_PC_OLD;
            alu_src_b = SRCB_IMM;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        mem_we  = (cls == CL_STORE);
      end
      S_WB: begin
        reg_write = 1'b1;
        wb_sel    = (cls == CL_LOAD) ? WB_MDR : WB_ALUOUT;
      end
`ifdef CU_TRAP_EN
      S_TRAP: begin
        fault      = 1'b1;
        trap_cause = cause;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mc_control_unit.sv
// tb_mc_control_unit: table-driven bench for mc_control_unit. Each vector
// drives rst/opcode/mem_ack for one cycle and compares all control outputs,
// packed into one word, against hand-built expectations. Trap behaviour is
// exercised in hand-written sequences whose expectations follow CU_TRAP_EN.
module tb_mc_control_unit;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_BAD    = 7'b1111111;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode;
  logic       mem_ack;
  logic       mem_req, mem_we, iord, ir_write, pc_write;
  logic [1:0] pc_src, alu_src_a, alu_src_b, alu_op;
  logic       branch, reg_write;
  logic [1:0] wb_sel;
  logic       fault;
  logic [1:0] trap_cause;

  mc_control_unit #(.MEM_TIMEOUT(4), .TO_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .mem_ack    (mem_ack),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .iord       (iord),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .branch     (branch),
    .reg_write  (reg_write),
    .wb_sel     (wb_sel),
    .fault      (fault),
    .trap_cause (trap_cause)
  );

  always #5 clk = ~clk;

  // {req, we, iord, irw, pcw, pc_src, a, b, op, branch, regw, wb_sel, fault, cause}
  logic [19:0] obs;
  assign obs = {mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a,
                alu_src_b, alu_op, branch, reg_write, wb_sel, fault, trap_cause};

  function automatic logic [19:0] mk(
    input logic req, input logic we, input logic io, input logic irw,
    input logic pcw, input logic [1:0] pcs, input logic [1:0] a,
    input logic [1:0] b, input logic [1:0] op, input logic br,
    input logic rw, input logic [1:0] wb, input logic flt,
    input logic [1:0] tc);
    return {req, we, io, irw, pcw, pcs, a, b, op, br, rw, wb, flt, tc};
  endfunction

  typedef struct {
    logic        rst;
    logic [6:0]  op;
    logic        ack;
    logic [19:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];
  int   nvec  = 0;
  int   nmiss = 0;

  logic [19:0] E_ZERO, E_FACK, E_FWAIT, E_DEC, E_EXR, E_EXI, E_EXLS, E_EXBR;
  logic [19:0] E_EXJAL, E_EXJALR, E_EXLUI, E_EXAUIPC, E_MEMRD, E_MEMWR;
  logic [19:0] E_WBALU, E_WBLD, E_TRAPILL, E_TRAPTO;

  task automatic addVec(input logic r, input logic [6:0] op, input logic ack,
                        input logic [19:0] exp, input string name);
    vec_t v;
    v.rst = r; v.op = op; v.ack = ack; v.exp = exp; v.name = name;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input logic r, input logic [6:0] op,
                               input logic ack);
    @(negedge clk);
    rst     = r;
    opcode  = op;
    mem_ack = ack;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [19:0] exp);
    nvec++;
    if (obs !== exp) begin
      nmiss++;
      $display("[TB] FAIL %s: got %05h expected %05h", name, obs, exp);
    end
  endtask

  task automatic doReset(input string name);
    applyStimulus(1'b1, OP_R, 1'b0);
    applyStimulus(1'b0, OP_R, 1'b0);
    checkOutput(name, E_ZERO);
  endtask

  initial begin
    E_ZERO    = '0;
    E_FACK    = mk(1,0,0,1,1,2'b00,2'b00,2'b10,2'b00,0,0,2'b00,0,2'b00);
    E_FWAIT   = mk(1,0,0,0,0,2'b00,2'b00,2'b10,2'b00,0,0,2'b00,0,2'b00);
    E_DEC     = mk(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,0,0,2'b00,0,2'b00);
    E_EXR     = mk(0,0,0,0,0,2'b00,2'b10,2'b00,2'b10,0,0,2'b00,0,2'b00);
    E_EXI     = mk(0,0,0,0,0,2'b00,2'b10,2'b01,2'b11,0,0,2'b00,0,2'b00);
    E_EXLS    = mk(0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,0,0,2'b00,0,2'b00);
    E_EXBR    = mk(0,0,0,0,0,2'b01,2'b10,2'b00,2'b01,1,0,2'b00,0,2'b00);
    E_EXJAL   = mk(0,0,0,0,1,2'b01,2'b00,2'b00,2'b00,0,1,2'b10,0,2'b00);
    E_EXJALR  = mk(0,0,0,0,1,2'b00,2'b10,2'b01,2'b00,0,1,2'b10,0,2'b00);
    E_EXLUI   = mk(0,0,0,0,0,2'b00,2'b11,2'b01,2'b00,0,0,2'b00,0,2'b00);
    E_EXAUIPC = mk(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,0,0,2'b00,0,2'b00);
    E_MEMRD   = mk(1,0,1,0,0,2'b00,2'b00,2'b00,2'b00,0,0,2'b00,0,2'b00);
    E_MEMWR   = mk(1,1,1,0,0,2'b00,2'b00,2'b00,2'b00,0,0,2'b00,0,2'b00);
    E_WBALU   = mk(0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,0,1,2'b00,0,2'b00);
    E_WBLD    = mk(0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,0,1,2'b01,0,2'b00);
    E_TRAPILL = mk(0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,0,0,2'b00,1,2'b01);
    E_TRAPTO  = mk(0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,0,0,2'b00,1,2'b10);

    // Reset, then R-type with zero-wait memory.
    addVec(1, OP_R, 1, E_ZERO,  "rst_hold");
    addVec(0, OP_R, 1, E_ZERO,  "rst_state");
    addVec(0, OP_R, 1, E_FACK,  "r_fetch");
    addVec(0, OP_R, 1, E_DEC,   "r_decode");
    addVec(0, OP_R, 1, E_EXR,   "r_exec");
    addVec(0, OP_R, 1, E_WBALU, "r_wb");
    // LOAD with 3 wait states; ack lands exactly at count MEM_TIMEOUT-1.
    addVec(0, OP_LOAD, 1, E_FACK,  "ld_fetch");
    addVec(0, OP_LOAD, 1, E_DEC,   "ld_decode");
    addVec(0, OP_LOAD, 1, E_EXLS,  "ld_exec");
    addVec(0, OP_LOAD, 0, E_MEMRD, "ld_mem_w1");
    addVec(0, OP_LOAD, 0, E_MEMRD, "ld_mem_w2");
    addVec(0, OP_LOAD, 0, E_MEMRD, "ld_mem_w3");
    addVec(0, OP_LOAD, 1, E_MEMRD, "ld_mem_ack");
    addVec(0, OP_LOAD, 1, E_WBLD,  "ld_wb");
    // STORE, zero wait.
    addVec(0, OP_STORE, 1, E_FACK,  "st_fetch");
    addVec(0, OP_STORE, 1, E_DEC,   "st_decode");
    addVec(0, OP_STORE, 1, E_EXLS,  "st_exec");
    addVec(0, OP_STORE, 1, E_MEMWR, "st_mem");
    // BRANCH, JAL, JALR: 3 cycles each.
    addVec(0, OP_BRANCH, 1, E_FACK,   "br_fetch");
    addVec(0, OP_BRANCH, 1, E_DEC,    "br_decode");
    addVec(0, OP_BRANCH, 1, E_EXBR,   "br_exec");
    addVec(0, OP_JAL,    1, E_FACK,   "jal_fetch");
    addVec(0, OP_JAL,    1, E_DEC,    "jal_decode");
    addVec(0, OP_JAL,    1, E_EXJAL,  "jal_exec");
    addVec(0, OP_JALR,   1, E_FACK,   "jalr_fetch");
    addVec(0, OP_JALR,   1, E_DEC,    "jalr_decode");
    addVec(0, OP_JALR,   1, E_EXJALR, "jalr_exec");
    // IALU, LUI, AUIPC.
    addVec(0, OP_IALU,  1, E_FACK,    "ialu_fetch");
    addVec(0, OP_IALU,  1, E_DEC,     "ialu_decode");
    addVec(0, OP_IALU,  1, E_EXI,     "ialu_exec");
    addVec(0, OP_IALU,  1, E_WBALU,   "ialu_wb");
    addVec(0, OP_LUI,   1, E_FACK,    "lui_fetch");
    addVec(0, OP_LUI,   1, E_DEC,     "lui_decode");
    addVec(0, OP_LUI,   1, E_EXLUI,   "lui_exec");
    addVec(0, OP_LUI,   1, E_WBALU,   "lui_wb");
    addVec(0, OP_AUIPC, 1, E_FACK,    "auipc_fetch");
    addVec(0, OP_AUIPC, 1, E_DEC,     "auipc_decode");
    addVec(0, OP_AUIPC, 1, E_EXAUIPC, "auipc_exec");
    addVec(0, OP_AUIPC, 1, E_WBALU,   "auipc_wb");
    // STORE with one wait, then straight back to FETCH.
    addVec(0, OP_STORE, 1, E_FACK,  "st2_fetch");
    addVec(0, OP_STORE, 1, E_DEC,   "st2_decode");
    addVec(0, OP_STORE, 1, E_EXLS,  "st2_exec");
    addVec(0, OP_STORE, 0, E_MEMWR, "st2_mem_w1");
    addVec(0, OP_STORE, 1, E_MEMWR, "st2_mem_ack");
    addVec(0, OP_R,     1, E_FACK,  "st2_next_fetch");
    addVec(0, OP_R,     1, E_DEC,   "r2_decode");
    addVec(0, OP_R,     1, E_EXR,   "r2_exec");
    addVec(0, OP_R,     1, E_WBALU, "r2_wb");
    // Reset asserted while MEM waits: request drops, no write-back follows.
    addVec(0, OP_LOAD, 1, E_FACK,  "ldr_fetch");
    addVec(0, OP_LOAD, 1, E_DEC,   "ldr_decode");
    addVec(0, OP_LOAD, 1, E_EXLS,  "ldr_exec");
    addVec(0, OP_LOAD, 0, E_MEMRD, "ldr_mem_w1");
    addVec(1, OP_LOAD, 0, E_MEMRD, "ldr_mem_rst");
    addVec(0, OP_R,    1, E_ZERO,  "ldr_reset_state");
    addVec(0, OP_R,    1, E_FACK,  "ldr_refetch");
    addVec(0, OP_R,    1, E_DEC,   "r3_decode");
    addVec(0, OP_R,    1, E_EXR,   "r3_exec");
    addVec(0, OP_R,    1, E_WBALU, "r3_wb");

    rst = 1'b1; opcode = OP_R; mem_ack = 1'b0;
    @(posedge clk);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].op, vecs[i].ack);
      checkOutput(vecs[i].name, vecs[i].exp);
    end

    // Illegal opcode.
    doReset("ill_reset");
    applyStimulus(0, OP_BAD, 1); checkOutput("ill_fetch", E_FACK);
    applyStimulus(0, OP_BAD, 1); checkOutput("ill_decode", E_DEC);
`ifdef CU_TRAP_EN
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, OP_R, 1); checkOutput("ill_trap_hold", E_TRAPILL);
    end
    applyStimulus(1, OP_R, 1); checkOutput("ill_trap_rst", E_TRAPILL);
    applyStimulus(0, OP_R, 1); checkOutput("ill_trap_exit", E_ZERO);
`else
    applyStimulus(0, OP_R, 1); checkOutput("ill_nop_fetch", E_FACK);
    applyStimulus(0, OP_R, 1); checkOutput("ill_nop_decode", E_DEC);
`endif

    // Fetch with no ack.
    doReset("to_reset");
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0, OP_R, 0); checkOutput("to_fetch_wait", E_FWAIT);
    end
`ifdef CU_TRAP_EN
    applyStimulus(0, OP_R, 0); checkOutput("to_trap", E_TRAPTO);
    applyStimulus(0, OP_R, 1); checkOutput("to_trap_hold", E_TRAPTO);
    // Ack on the 4th request cycle beats the timeout.
    doReset("to2_reset");
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, OP_R, 0); checkOutput("to2_fetch_wait", E_FWAIT);
    end
    applyStimulus(0, OP_R, 1); checkOutput("to2_fetch_ack", E_FACK);
    applyStimulus(0, OP_R, 1); checkOutput("to2_decode", E_DEC);
    // Reset mid-wait restarts the count.
    doReset("to3_reset");
    applyStimulus(0, OP_R, 0); checkOutput("to3_wait1", E_FWAIT);
    applyStimulus(0, OP_R, 0); checkOutput("to3_wait2", E_FWAIT);
    applyStimulus(1, OP_R, 0); checkOutput("to3_rst", E_FWAIT);
    applyStimulus(0, OP_R, 0); checkOutput("to3_reset_state", E_ZERO);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, OP_R, 0); checkOutput("to3_rewait", E_FWAIT);
    end
    applyStimulus(0, OP_R, 1); checkOutput("to3_ack", E_FACK);
    applyStimulus(0, OP_R, 1); checkOutput("to3_decode", E_DEC);
`else
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0, OP_R, 0); checkOutput("nto_fetch_wait", E_FWAIT);
    end
    applyStimulus(0, OP_R, 1); checkOutput("nto_fetch_ack", E_FACK);
    applyStimulus(0, OP_R, 1); checkOutput("nto_decode", E_DEC);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmiss);
    $finish;
  end

endmodule
